// File: rtl/fp_quant_pkg.sv
// fp_quant_pkg: shared FSM states and field helpers for sign-magnitude floats of arbitrary EXP_W/MAN_W
package fp_quant_pkg;
   localparam int MAX_DW = 64;
   typedef logic [MAX_DW-1:0] word_t;
   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
   function automatic logic field_sign(input word_t v, input int exp_w, input int man_w);
      return v[exp_w+man_w];
   endfunction
   function automatic word_t field_exp(input word_t v, input int exp_w, input int man_w);
      return (v >> man_w) & ((word_t'(1) << exp_w) - word_t'(1));
   endfunction
   function automatic word_t field_man(input word_t v, input int man_w);
      return v & ((word_t'(1) << man_w) - word_t'(1));
   endfunction
   function automatic logic is_nan(input word_t v, input int exp_w, input int man_w);
      return field_exp(v, exp_w, man_w) == ((word_t'(1) << exp_w) - word_t'(1)) && field_man(v, man_w) != '0;
   endfunction
   function automatic logic is_zero(input word_t v, input int exp_w, input int man_w);
      return (v & ((word_t'(1) << (exp_w + man_w)) - word_t'(1))) == '0;
   endfunction
endpackage

// File: rtl/fp_sm_compare_ge.sv
// fp_sm_compare_ge: x >= t under sign-magnitude float order, +0 == -0, NaN threshold never reached
module fp_sm_compare_ge
   import fp_quant_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int DW = 1 + EXP_W + MAN_W
)(
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] t,
   output logic          ge
);
   logic sx, st, t_nan, both_zero;
   assign sx = field_sign(word_t'(x), EXP_W, MAN_W);
   assign st = field_sign(word_t'(t), EXP_W, MAN_W);
   assign t_nan = is_nan(word_t'(t), EXP_W, MAN_W);
   assign both_zero = is_zero(word_t'(x), EXP_W, MAN_W) && is_zero(word_t'(t), EXP_W, MAN_W);
   assign ge = t_nan     ? 1'b0 :
               both_zero ? 1'b1 :
               sx != st  ? !sx  :
               sx        ? (x[DW-2:0] <= t[DW-2:0]) : (x[DW-2:0] >= t[DW-2:0]);
endmodule

// File: rtl/fp_threshold_quantizer.sv
// fp_threshold_quantizer: float sample to level index via fixed-length binary search over a threshold table
module fp_threshold_quantizer
   import fp_quant_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int LEVELS = 16,
   localparam int IDX_W = $clog2(LEVELS),
   localparam int DW = 1 + EXP_W + MAN_W
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             thr_wr_en,
   input  logic [IDX_W-1:0] thr_wr_addr,
   input  logic [DW-1:0]    thr_wr_data,
   output logic             thr_wr_ready,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_level,
   output logic             out_nan,
   output logic             busy
);
   localparam int NT = LEVELS - 1;
   typedef logic [IDX_W:0] ptr_t;
   localparam ptr_t NT_P = ptr_t'(NT);
   state_t state, state_nx;
   logic [DW-1:0] thr [NT];
   logic [DW-1:0] x, x_nx, t_mid;
   ptr_t lo, lo_nx, hi, hi_nx, mid, cnt, cnt_nx;
   logic nan, nan_nx, ge, accept;
   assign in_ready = state == IDLE;
   assign thr_wr_ready = state == IDLE;
   assign busy = state != IDLE;
   assign out_valid = state == DONE;
   assign out_level = lo[IDX_W-1:0];
   assign out_nan = nan;
   assign accept = in_valid && in_ready;
   assign mid = (lo + hi) >> 1;
   assign t_mid = (mid < NT_P) ? thr[mid[IDX_W-1:0]] : '0;
   fp_sm_compare_ge #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cmp (.x(x), .t(t_mid), .ge(ge));
   always_comb begin
      state_nx = state;
      x_nx = x;
      lo_nx = lo;
      hi_nx = hi;
      cnt_nx = cnt;
      nan_nx = nan;
      case (state)
         IDLE: if (accept) begin
            x_nx = in_data;
            nan_nx = is_nan(word_t'(in_data), EXP_W, MAN_W);
            lo_nx = '0;
            hi_nx = NT_P;
            cnt_nx = '0;
            state_nx = nan_nx ? DONE : SEARCH;
         end
         SEARCH: begin
            lo_nx = (lo < hi && ge) ? mid + ptr_t'(1) : lo;
            hi_nx = (lo < hi && !ge) ? mid : hi;
            cnt_nx = cnt + ptr_t'(1);
            state_nx = (cnt == ptr_t'(IDX_W - 1)) ? DONE : SEARCH;
         end
         DONE: state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         x <= '0;
         lo <= '0;
         hi <= '0;
         cnt <= '0;
         nan <= 1'b0;
      end else begin
         state <= state_nx;
         x <= x_nx;
         lo <= lo_nx;
         hi <= hi_nx;
         cnt <= cnt_nx;
         nan <= nan_nx;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NT; i++) thr[i] <= '0;
      end else if (thr_wr_en && thr_wr_ready && ptr_t'(thr_wr_addr) < NT_P) begin
         thr[thr_wr_addr] <= thr_wr_data;
      end
   end
endmodule

// File: tb/tb_fp_threshold_quantizer.sv
// tb_fp_threshold_quantizer: directed and randomized checks of the float threshold quantizer against a value-order model
module tb_fp_threshold_quantizer;
   localparam int LEVELS = 4;
   localparam int NT = LEVELS - 1;
   localparam int IDX_W = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic thr_wr_en = 1'b0;
   logic [IDX_W-1:0] thr_wr_addr = '0;
   logic [31:0] thr_wr_data = '0;
   logic thr_wr_ready;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [31:0] in_data = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [IDX_W-1:0] out_level;
   logic out_nan;
   logic busy;
   logic [31:0] tm [NT];
   int n_assert = 0;
   int n_fail = 0;
   int edges = 0;
   always #5 clk = ~clk;
   fp_threshold_quantizer #(.EXP_W(8), .MAN_W(23), .LEVELS(LEVELS)) dut (
      .clk(clk), .rst_n(rst_n),
      .thr_wr_en(thr_wr_en), .thr_wr_addr(thr_wr_addr), .thr_wr_data(thr_wr_data), .thr_wr_ready(thr_wr_ready),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level), .out_nan(out_nan), .busy(busy)
   );
   function automatic bit fnan(input logic [31:0] v);
      return v[30:23] == 8'hFF && v[22:0] != 23'd0;
   endfunction
   function automatic longint key(input logic [31:0] v);
      longint m;
      m = longint'({33'd0, v[30:0]});
      return v[31] ? -m : m;
   endfunction
   function automatic int model_level(input logic [31:0] v);
      int c;
      c = 0;
      for (int k = 0; k < NT; k++) if (!fnan(tm[k]) && key(v) >= key(tm[k])) c++;
      return c;
   endfunction
   function automatic logic [31:0] rnd_f(input bit allow_nan);
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 7))
         0: v = 32'h0000_0000;
         1: v = 32'h8000_0000;
         2: v = 32'h7F80_0000;
         3: v = 32'hFF80_0000;
         4: if (allow_nan) v = {v[31], 8'hFF, v[22:1], 1'b1};
         default: v[30:23] = 8'(124 + $urandom_range(0, 7));
      endcase
      if (!allow_nan && fnan(v)) v[22:0] = 23'd0;
      return v;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      edges++;
   endtask
   task automatic wr(input int a, input logic [31:0] d);
      thr_wr_en = 1'b1;
      thr_wr_addr = IDX_W'(a);
      thr_wr_data = d;
      chk("wr_ready", 32'(thr_wr_ready), 32'd1);
      @(negedge clk);
      thr_wr_en = 1'b0;
      if (a < NT) tm[a] = d;
   endtask
   task automatic start(input logic [31:0] v);
      in_valid = 1'b1;
      in_data = v;
      chk("in_ready", 32'(in_ready), 32'd1);
      edges = 0;
      tick();
      in_valid = 1'b0;
   endtask
   task automatic finish(input string tag, input logic [31:0] v, input int hold);
      bit en;
      int lvl, lat;
      en = fnan(v);
      lvl = en ? 0 : model_level(v);
      lat = en ? 1 : IDX_W + 1;
      while (!out_valid && edges < 20) tick();
      chk({tag, "/valid"}, 32'(out_valid), 32'd1);
      chk({tag, "/latency"}, 32'(edges), 32'(lat));
      chk({tag, "/level"}, 32'(out_level), 32'(lvl));
      chk({tag, "/nan"}, 32'(out_nan), 32'(en));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "/hold_level"}, 32'(out_level), 32'(lvl));
         chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
         chk({tag, "/hold_wr_ready"}, 32'(thr_wr_ready), 32'd0);
         chk({tag, "/hold_busy"}, 32'(busy), 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "/idle_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "/idle_in_ready"}, 32'(in_ready), 32'd1);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [31:0] g [NT];
      logic [31:0] tmp, v;
      for (int k = 0; k < NT; k++) tm[k] = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst/valid", 32'(out_valid), 32'd0);
      chk("rst/busy", 32'(busy), 32'd0);
      chk("rst/level", 32'(out_level), 32'd0);
      chk("rst/nan", 32'(out_nan), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      wr(0, 32'hBF80_0000);
      wr(1, 32'h0000_0000);
      wr(2, 32'h3F80_0000);
      start(32'h3F00_0000); finish("half", 32'h3F00_0000, 0);
      start(32'h8000_0000); finish("neg_zero", 32'h8000_0000, 0);
      start(32'hC000_0000); finish("neg_two", 32'hC000_0000, 0);
      start(32'h7F80_0000); finish("pos_inf", 32'h7F80_0000, 0);
      start(32'h3F80_0000); finish("eq_one", 32'h3F80_0000, 0);
      start(32'h7FC0_0000); finish("nan", 32'h7FC0_0000, 0);
      start(32'hBF00_0000); finish("backpressure", 32'hBF00_0000, 5);
      start(32'h3F00_0000); finish("after_bp", 32'h3F00_0000, 0);
      start(32'h4000_0000);
      thr_wr_en = 1'b1;
      thr_wr_addr = 2'd2;
      thr_wr_data = 32'h4040_0000;
      chk("wr_during_search", 32'(thr_wr_ready), 32'd0);
      tick();
      thr_wr_en = 1'b0;
      finish("search_write", 32'h4000_0000, 0);
      wr(3, 32'h4040_0000);
      start(32'h4000_0000); finish("addr_oob", 32'h4000_0000, 0);
      thr_wr_en = 1'b1;
      thr_wr_addr = 2'd1;
      thr_wr_data = 32'h4000_0000;
      in_valid = 1'b1;
      in_data = 32'h3F00_0000;
      chk("same/wr_ready", 32'(thr_wr_ready), 32'd1);
      chk("same/in_ready", 32'(in_ready), 32'd1);
      edges = 0;
      tick();
      thr_wr_en = 1'b0;
      in_valid = 1'b0;
      tm[1] = 32'h4000_0000;
      chk("same/model", 32'(model_level(32'h3F00_0000)), 32'd1);
      finish("same_cycle", 32'h3F00_0000, 0);
      start(32'h3F00_0000);
      tick();
      rst_n = 1'b0;
      #1;
      chk("async_rst/valid", 32'(out_valid), 32'd0);
      chk("async_rst/busy", 32'(busy), 32'd0);
      for (int k = 0; k < NT; k++) tm[k] = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start(32'h3F00_0000); finish("post_rst", 32'h3F00_0000, 0);
      for (int it = 0; it < 48; it++) begin
         if (it % 8 == 0) begin
            for (int k = 0; k < NT; k++) g[k] = rnd_f(1'b0);
            for (int a = 0; a < NT - 1; a++)
               for (int b = 0; b < NT - 1 - a; b++)
                  if (key(g[b]) > key(g[b+1])) begin
                     tmp = g[b];
                     g[b] = g[b+1];
                     g[b+1] = tmp;
                  end
            if ($urandom_range(0, 7) == 0) g[NT-1] = 32'h7FC0_0001;
            for (int k = 0; k < NT; k++) wr(k, g[k]);
         end
         v = ($urandom_range(0, 3) == 0) ? tm[$urandom_range(0, NT - 1)] : rnd_f(1'b1);
         start(v);
         finish("random", v, int'($urandom_range(0, 2)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
